mem_arbiter: RTL
================

# mem_arbiter

Shares the single-port, fixed-latency unified memory between the instruction-fetch requester (stage 1) and the data requester (stage 4 load/store). It is a request/grant arbiter with a sequencing FSM: it accepts one access at a time, drives the memory command, waits out the memory latency and returns the response to the winning requester. Data accesses have priority; a starvation counter guarantees fetch forward progress. It replaces the direct two-port hookup of the memory controller and gives the pipeline a real back-pressure source.

## Interface
- `MEM_LAT`, 2: memory read latency in cycles, from command cycle to data-valid cycle; legal range 1..15.
- `STARVE_MAX`, 4: consecutive lost arbitrations after which fetch wins; legal range 1..15.
- `i_clk`  input  1  clock; all state updates on posedge.
- `i_rst`  input  1  reset; synchronous, active-low.
- `i_d_req`  input  1  data request; held with stable payload until `o_d_gnt`.
- `i_d_we`  input  1  data write (1) / read (0).
- `i_d_addr`  input  32  data byte address.
- `i_d_wdata`  input  32  store data.
- `i_d_be`  input  4  byte enables (one-hot/pair/all-four, formed by requester).
- `o_d_gnt`  output  1  data request accepted this cycle (combinational).
- `o_d_rvalid`  output  1  one-cycle response pulse: read data valid, or write ack.
- `o_d_rdata`  output  32  read data, or 0 for writes.
- `i_f_req`  input  1  fetch request; held with stable address until `o_f_gnt`.
- `i_f_addr`  input  32  fetch address (word aligned).
- `o_f_gnt`  output  1  fetch accepted this cycle (combinational).
- `o_f_rvalid`  output  1  one-cycle instruction-valid pulse.
- `o_f_rdata`  output  32  instruction word.
- `o_m_en`  output  1  memory command strobe.
- `o_m_we`  output  1  memory write.
- `o_m_addr`  output  32  memory address.
- `o_m_wdata`  output  32  memory write data.
- `o_m_be`  output  4  memory byte enables.
- `i_m_rdata`  input  32  memory read data, valid exactly `MEM_LAT` cycles after an `o_m_en` cycle.
- `o_busy`  output  1  an access is in flight (state not IDLE).

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration happens in IDLE and RESP only. Winner rule: if `i_d_req` and `i_f_req` are both set, data wins unless starve count equals `STARVE_MAX`, in which case fetch wins. A lone requester always wins. The winner's gnt is asserted that cycle, the request is latched (owner, we, addr, wdata, be), and the next state is ISSUE.
- ISSUE: `o_m_en`=1 with the latched command. Fetch forces we=0 and be=4'hF. Latency counter is loaded to 1; next state is WAIT.
- WAIT: counter increments each cycle. In the cycle where counter equals `MEM_LAT`, `i_m_rdata` is captured (reads only) and the next state is RESP.
- RESP: the owner's rvalid is asserted for one cycle with the captured data (0 for writes). The non-owner's rvalid stays 0. If a new grant happens in the same cycle, next state is ISSUE; otherwise IDLE.
- Starve counter rules:
  - Increments (saturating at `STARVE_MAX`) on each arbitration where fetch requests and data wins.
  - Clears when fetch is granted, or in any arbitration cycle where `i_f_req`=0.
- `o_m_*` other than `o_m_en` hold their last value when `o_m_en`=0. Memory ignores them.
- Reset (`i_rst`=0 at a posedge): the following all go to 0 next cycle:
  - state = IDLE;
  - counters;
  - all gnt, rvalid and `o_m_en` outputs;
  - latched command and rdata registers.

  An in-flight access is abandoned; its late `i_m_rdata` is ignored. Gnt is suppressed while `i_rst`=0.

## Timing
- Request in cycle 0 with the arbiter free: gnt in cycle 0, `o_m_en` in cycle 1, data sampled at the end of cycle 1+`MEM_LAT`, rvalid in cycle 2+`MEM_LAT` (`MEM_LAT`=2 gives rvalid in cycle 4).
- Back-to-back throughput: one access every `MEM_LAT`+2 cycles; the next gnt can coincide with the previous rvalid.
- Write ack timing is identical to read timing.
- No request is ever dropped or duplicated. A requester that deasserts before gnt is simply not served.

## Structure
- Shared package `riscv_mem_pkg`:
  - state encoding constants: `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`;
  - owner constants: `OWN_D`, `OWN_F`;
  - default `MEM_LAT`.
- One sub-module: `starve_counter` (saturating counter with inc/clear and an `at_max` flag). The FSM, latches and muxes stay in `mem_arbiter`.

## Test plan
- Lone data read, addr 0x40, memory returns 0xDEADBEEF at `MEM_LAT`=2 → gnt in cycle 0, `o_m_en` in cycle 1 with addr 0x40 and be 4'hF, `o_d_rvalid` with 0xDEADBEEF in cycle 4, `o_f_rvalid` stays 0.
- Simultaneous data write (addr 0x80, wdata 0x12345678, be 4'b0011) and fetch (addr 0x0) → data granted first; write ack with rdata 0 in cycle 4; fetch gnt in cycle 4; instruction rvalid in cycle 8.
- `i_d_req` and `i_f_req` held high continuously with `STARVE_MAX`=4 → grant order D,D,D,D,F, repeating; fetch never waits more than 5 access slots.
- Back-to-back fetches of 0x0 and 0x4 → second gnt coincides with first rvalid; there are exactly `MEM_LAT`+2 cycles between rvalid pulses.
- Reset asserted in WAIT, with memory then returning 0xCAFEF00D → next cycle all outputs are 0 and `o_busy`=0; no rvalid for the abandoned access; a fresh request after reset completes normally.
- `MEM_LAT`=1 build, single read → rvalid in cycle 3.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Contents: arbiter state encoding, access owner encoding, default latency and
// starvation limits, the latched command record and a helper that builds a fetch command.
package riscv_mem_pkg;

  localparam int unsigned DEF_MEM_LAT    = 2;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Width of the latency and starvation counters; both parameters top out at 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_F = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  // Fetches are always full-word reads.
  function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
    mem_cmd_t c;
    c.owner = OWN_F;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = '0;
    c.be    = 4'hF;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the data-requester, fetch-requester and memory-command signals.
// slave  : arbiter side (takes requests and read data, drives grants, responses and commands).
// master : environment side (requesters plus memory model).
// d_* : data port  (req/we/addr/wdata/be in, gnt/rvalid/rdata out)
// f_* : fetch port (req/addr in, gnt/rvalid/rdata out)
// m_* : memory port (en/we/addr/wdata/be out, rdata in)
interface mem_arbiter_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );
endinterface

// File: rtl/starve_counter.sv
// Saturating count of consecutive arbitrations the fetch requester has lost.
// i_clk    : clock
// i_rst    : synchronous active-low reset
// i_inc    : fetch lost an arbitration (saturates at MAX)
// i_clr    : fetch granted, or fetch not requesting in an arbitration cycle (wins over i_inc)
// o_at_max : count has reached MAX; fetch must win the next contested arbitration
module starve_counter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX = DEF_STARVE_MAX
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between instruction fetch and
// data load/store. One access in flight at a time: grant, issue, wait MEM_LAT, respond.
// Data has priority; fetch wins a contested slot after STARVE_MAX consecutive losses.
// i_clk  : clock
// i_rst  : synchronous active-low reset; abandons any in-flight access
// bus    : requester / memory signals (slave modport)
// o_busy : an access is in flight
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mem_arbiter_if.slave bus,
  output logic        o_busy
);

  localparam logic [CNT_W-1:0] LatLast = CNT_W'(MEM_LAT);

  arb_state_e       state_q, state_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [31:0]      rdata_q, rdata_d;

  logic arb_cycle;
  logic f_wins;
  logic d_wins;
  logic grant;
  logic starve_at_max;
  logic lat_done;

  // Arbitration only when no access occupies the memory; never during reset.
  assign arb_cycle = i_rst && ((state_q == ARB_IDLE) || (state_q == ARB_RESP));
  assign f_wins    = bus.f_req && (!bus.d_req || starve_at_max);
  assign d_wins    = bus.d_req && !f_wins;
  assign grant     = arb_cycle && (bus.d_req || bus.f_req);
  assign lat_done  = (state_q == ARB_WAIT) && (lat_q == LatLast);

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (arb_cycle && bus.f_req && d_wins),
    .i_clr    (arb_cycle && (!bus.f_req || f_wins)),
    .o_at_max (starve_at_max)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (grant) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (lat_done) state_d = ARB_RESP;
      ARB_RESP:  state_d = grant ? ARB_ISSUE : ARB_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.d_gnt    = 1'b0;
    bus.f_gnt    = 1'b0;
    bus.m_en     = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.f_rvalid = 1'b0;
    o_busy       = 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        bus.d_gnt = arb_cycle && d_wins;
        bus.f_gnt = arb_cycle && f_wins;
        o_busy    = 1'b0;
      end
      ARB_ISSUE: bus.m_en = 1'b1;
      ARB_WAIT:  ;
      ARB_RESP: begin
        bus.d_gnt    = arb_cycle && d_wins;
        bus.f_gnt    = arb_cycle && f_wins;
        bus.d_rvalid = (cmd_q.owner == OWN_D);
        bus.f_rvalid = (cmd_q.owner == OWN_F);
      end
    endcase
  end

  // Command latch, latency counter and read-data capture.
  always_comb begin
    cmd_d   = cmd_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    if (grant) begin
      if (f_wins) begin
        cmd_d = fetch_cmd(bus.f_addr);
      end else begin
        cmd_d = '{owner: OWN_D, we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata,
                  be: bus.d_be};
      end
    end
    if (state_q == ARB_ISSUE) begin
      lat_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (state_q == ARB_WAIT) begin
      lat_d = lat_q + 1'b1;
    end
    if (lat_done) begin
      rdata_d = cmd_q.we ? 32'h0 : bus.m_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cmd_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      cmd_q   <= cmd_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  // Command fields only change when a new access is latched, so they hold while m_en is low.
  assign bus.m_we    = cmd_q.we;
  assign bus.m_addr  = cmd_q.addr;
  assign bus.m_wdata = cmd_q.wdata;
  assign bus.m_be    = cmd_q.be;
  assign bus.d_rdata = rdata_q;
  assign bus.f_rdata = rdata_q;

endmodule
